// File: rtl/cfi_lpad_monitor_if.sv
// Commit-stage observation bundle: per-port commit strobe, decoded op and PC.
// Latency: none (wires only).
// Backpressure: none; the commit stage drives, monitors only listen.
// Signals:
//   commit_ack  NR_PORTS       per-port commit strobe
//   commit_op   NR_PORTS*OP_W  per-port decoded op, port i at [i*OP_W +: OP_W]
//   commit_pc   NR_PORTS*XLEN  per-port PC, port i at [i*XLEN +: XLEN]
interface cfi_lpad_monitor_if #(
    parameter int NR_PORTS = 2,
    parameter int OP_W     = 8,
    parameter int XLEN     = 64
);
    logic [NR_PORTS-1:0]      commit_ack;
    logic [NR_PORTS*OP_W-1:0] commit_op;
    logic [NR_PORTS*XLEN-1:0] commit_pc;

    modport master (output commit_ack, commit_op, commit_pc);
    modport slave  (input  commit_ack, commit_op, commit_pc);
endinterface

// File: rtl/cfi_lpad_monitor.sv
// CFI monitor: every committed JALR must reach an LPAD within WINDOW committed instructions.
// Latency: 1 cycle from the commit cycle to violation_o / alert_o / viol_pc_o / viol_cnt_o.
// Backpressure: none; passive observer, never stalls the commit stage.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   en_i, clear_i        monitor enable, clear of sticky alert/count/pc and LOCKED
//   commit_if (slave)    commit ack/op/pc of all ports
//   violation_o          one-cycle pulse per cycle containing >=1 violation
//   alert_o, viol_pc_o   sticky flag, JALR PC of first violation of latest violating cycle
//   viol_cnt_o, state_o  saturating violation count, 00 IDLE / 01 ARMED / 10 LOCKED
module cfi_lpad_monitor #(
    parameter int              NR_PORTS     = 2,
    parameter int              OP_W         = 8,
    parameter int              XLEN         = 64,
    parameter logic [OP_W-1:0] JALR_OP      = OP_W'(8'h2C),
    parameter logic [OP_W-1:0] LPAD_OP      = OP_W'(8'h00),
    parameter int              WINDOW       = 1,
    parameter int              CNT_W        = 16,
    parameter bit              LOCK_ON_VIOL = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clear_i,
    cfi_lpad_monitor_if.slave    commit_if,
    output logic                 violation_o,
    output logic                 alert_o,
    output logic [XLEN-1:0]      viol_pc_o,
    output logic [CNT_W-1:0]     viol_cnt_o,
    output logic [1:0]           state_o
);
    localparam int RW    = $clog2(WINDOW + 1);
    localparam int NV_W  = $clog2(NR_PORTS + 1);
    localparam int SUM_W = CNT_W + NV_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{NV_W{1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_remaining;
    logic [XLEN-1:0]   r_armed_pc;
    logic              r_viol;
    logic              r_alert;
    logic [XLEN-1:0]   r_viol_pc;
    logic [CNT_W-1:0]  r_viol_cnt;

    state_t            w_state;
    state_t            w_next;
    logic [RW-1:0]     w_rem;
    logic [XLEN-1:0]   w_apc;
    logic [NV_W-1:0]   w_nviol;
    logic [XLEN-1:0]   w_first_pc;
    logic [OP_W-1:0]   w_op;
    logic [XLEN-1:0]   w_pc;
    logic              w_hit;
    logic              w_any;
    logic [CNT_W-1:0]  w_cnt_base;
    logic [SUM_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_cnt_sat;

    // Ports are walked in index order on a running copy of the state so a
    // JALR and its successor committing in the same cycle interact exactly
    // as if they had committed one after the other.
    always_comb begin
        w_state    = r_state;
        w_rem      = r_remaining;
        w_apc      = r_armed_pc;
        w_nviol    = '0;
        w_first_pc = '0;
        w_op       = '0;
        w_pc       = '0;
        w_hit      = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            w_op  = commit_if.commit_op[i*OP_W +: OP_W];
            w_pc  = commit_if.commit_pc[i*XLEN +: XLEN];
            w_hit = 1'b0;
            if (en_i && commit_if.commit_ack[i]) begin
                case (w_state)
                    ST_IDLE: begin
                        if (w_op == JALR_OP) begin
                            w_state = ST_ARMED;
                            w_rem   = RW'(WINDOW);
                            w_apc   = w_pc;
                        end
                    end
                    ST_ARMED: begin
                        if (w_op == LPAD_OP) begin
                            w_state = ST_IDLE;
                        end else begin
                            if (w_op == JALR_OP) begin
                                w_hit = 1'b1;
                            end else begin
                                w_rem = w_rem - RW'(1);
                                w_hit = (w_rem == '0);
                            end
                            if (w_hit) begin
                                if (w_nviol == '0) w_first_pc = w_apc;
                                w_nviol = w_nviol + NV_W'(1);
                            end
                            // Locking takes priority over re-arming on a nested JALR.
                            if (w_hit && LOCK_ON_VIOL) begin
                                w_state = ST_LOCKED;
                            end else if (w_op == JALR_OP) begin
                                w_rem = RW'(WINDOW);
                                w_apc = w_pc;
                            end else if (w_hit) begin
                                w_state = ST_IDLE;
                            end
                        end
                    end
                    default: ;  // LOCKED ignores everything until clear_i
                endcase
            end
        end

        w_any = (w_nviol != '0);

        // A violation that locks in the same cycle as clear_i keeps the lock.
        if (!en_i)
            w_next = ST_IDLE;
        else if (clear_i && !w_any && w_state == ST_LOCKED)
            w_next = ST_IDLE;
        else
            w_next = w_state;

        w_cnt_base = clear_i ? '0 : r_viol_cnt;
        w_sum      = {{NV_W{1'b0}}, w_cnt_base} + {{CNT_W{1'b0}}, w_nviol};
        w_cnt_sat  = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_armed_pc  <= '0;
            r_viol      <= 1'b0;
            r_alert     <= 1'b0;
            r_viol_pc   <= '0;
            r_viol_cnt  <= '0;
        end else begin
            r_state     <= w_next;
            r_remaining <= w_rem;
            r_armed_pc  <= w_apc;
            r_viol      <= w_any;
            if (w_any) begin
                r_alert    <= 1'b1;
                r_viol_pc  <= w_first_pc;
                r_viol_cnt <= w_cnt_sat;
            end else if (clear_i) begin
                r_alert    <= 1'b0;
                r_viol_pc  <= '0;
                r_viol_cnt <= '0;
            end
        end
    end

    assign violation_o = r_viol;
    assign alert_o     = r_alert;
    assign viol_pc_o   = r_viol_pc;
    assign viol_cnt_o  = r_viol_cnt;
    assign state_o     = r_state;
endmodule

// File: tb/tb_cfi_lpad_monitor.sv
// Bench for cfi_lpad_monitor: five configurations share one commit stream.
// Latency: outputs checked #1 after the edge that registers each commit cycle.
// Backpressure: n/a.
module tb_cfi_lpad_monitor;
    localparam logic [7:0] OP_JALR = 8'h2C;
    localparam logic [7:0] OP_LPAD = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h33;

    logic core_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b1;
    logic clear    = 1'b0;

    always #5 core_clk = ~core_clk;

    cfi_lpad_monitor_if #(.NR_PORTS(2), .OP_W(8), .XLEN(64)) cif ();

    // W1: strict next, W3/W2: wider windows, LK: lock mode 2-bit count, SAT: 2-bit count
    logic viol_w1, alert_w1, viol_w3, alert_w3, viol_w2, alert_w2;
    logic viol_lk, alert_lk, viol_sat, alert_sat;
    logic [63:0] pc_w1, pc_w3, pc_w2, pc_lk, pc_sat;
    logic [15:0] cnt_w1, cnt_w3, cnt_w2;
    logic [1:0]  cnt_lk, cnt_sat;
    logic [1:0]  st_w1, st_w3, st_w2, st_lk, st_sat;

    cfi_lpad_monitor #(.WINDOW(1)) u_w1 (
        .clk_i(core_clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .commit_if(cif),
        .violation_o(viol_w1), .alert_o(alert_w1), .viol_pc_o(pc_w1),
        .viol_cnt_o(cnt_w1), .state_o(st_w1));
    cfi_lpad_monitor #(.WINDOW(3)) u_w3 (
        .clk_i(core_clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .commit_if(cif),
        .violation_o(viol_w3), .alert_o(alert_w3), .viol_pc_o(pc_w3),
        .viol_cnt_o(cnt_w3), .state_o(st_w3));
    cfi_lpad_monitor #(.WINDOW(2)) u_w2 (
        .clk_i(core_clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .commit_if(cif),
        .violation_o(viol_w2), .alert_o(alert_w2), .viol_pc_o(pc_w2),
        .viol_cnt_o(cnt_w2), .state_o(st_w2));
    cfi_lpad_monitor #(.WINDOW(1), .CNT_W(2), .LOCK_ON_VIOL(1'b1)) u_lk (
        .clk_i(core_clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .commit_if(cif),
        .violation_o(viol_lk), .alert_o(alert_lk), .viol_pc_o(pc_lk),
        .viol_cnt_o(cnt_lk), .state_o(st_lk));
    cfi_lpad_monitor #(.WINDOW(1), .CNT_W(2), .LOCK_ON_VIOL(1'b0)) u_sat (
        .clk_i(core_clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .commit_if(cif),
        .violation_o(viol_sat), .alert_o(alert_sat), .viol_pc_o(pc_sat),
        .viol_cnt_o(cnt_sat), .state_o(st_sat));

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one commit cycle, then land #1 after the edge that registers it.
    task automatic drv(input logic [1:0] ack, input logic [7:0] op0, input logic [63:0] pc0,
                       input logic [7:0] op1, input logic [63:0] pc1);
        cif.commit_ack = ack;
        cif.commit_op  = {op1, op0};
        cif.commit_pc  = {pc1, pc0};
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle();
        drv(2'b00, OP_ADD, 64'h0, OP_ADD, 64'h0);
    endtask

    task automatic do_reset();
        cif.commit_ack = 2'b00;
        rst_n = 1'b0;
        @(posedge core_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        cif.commit_ack = 2'b00;
        cif.commit_op  = '0;
        cif.commit_pc  = '0;

        // reset state
        do_reset();
        check_eq("rst_viol", {63'd0, viol_w1}, 64'd0);
        check_eq("rst_alert", {63'd0, alert_w1}, 64'd0);
        check_eq("rst_pc", pc_w1, 64'd0);
        check_eq("rst_cnt", {48'd0, cnt_w1}, 64'd0);
        check_eq("rst_state", {62'd0, st_w1}, 64'd0);

        // W=1: JALR then LPAD next
        drv(2'b01, OP_JALR, 64'h8000_0010, OP_ADD, 64'h0);
        check_eq("w1_lpad_armed", {62'd0, st_w1}, 64'd1);
        check_eq("w1_lpad_noviol0", {63'd0, viol_w1}, 64'd0);
        drv(2'b01, OP_LPAD, 64'h8000_0014, OP_ADD, 64'h0);
        check_eq("w1_lpad_idle", {62'd0, st_w1}, 64'd0);
        check_eq("w1_lpad_noviol1", {63'd0, viol_w1}, 64'd0);
        check_eq("w1_lpad_noalert", {63'd0, alert_w1}, 64'd0);

        // W=1: JALR and ADD in one cycle, then a clear
        do_reset();
        drv(2'b11, OP_JALR, 64'h100, OP_ADD, 64'h104);
        check_eq("w1_add_viol", {63'd0, viol_w1}, 64'd1);
        check_eq("w1_add_alert", {63'd0, alert_w1}, 64'd1);
        check_eq("w1_add_pc", pc_w1, 64'h100);
        check_eq("w1_add_cnt", {48'd0, cnt_w1}, 64'd1);
        check_eq("w1_add_state", {62'd0, st_w1}, 64'd0);
        idle();
        check_eq("w1_pulse_end", {63'd0, viol_w1}, 64'd0);
        check_eq("w1_alert_sticky", {63'd0, alert_w1}, 64'd1);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check_eq("w1_clr_alert", {63'd0, alert_w1}, 64'd0);
        check_eq("w1_clr_cnt", {48'd0, cnt_w1}, 64'd0);
        check_eq("w1_clr_pc", pc_w1, 64'd0);

        // W=3: two non-LPAD with gaps, then LPAD
        do_reset();
        drv(2'b01, OP_JALR, 64'h200, OP_ADD, 64'h0);
        idle();
        drv(2'b10, OP_JALR, 64'h0, OP_ADD, 64'h204);
        idle();
        drv(2'b01, OP_ADD, 64'h208, OP_ADD, 64'h0);
        check_eq("w3_ok_armed", {62'd0, st_w3}, 64'd1);
        drv(2'b01, OP_LPAD, 64'h20C, OP_ADD, 64'h0);
        check_eq("w3_ok_noviol", {63'd0, viol_w3}, 64'd0);
        check_eq("w3_ok_noalert", {63'd0, alert_w3}, 64'd0);
        check_eq("w3_ok_idle", {62'd0, st_w3}, 64'd0);

        // W=3: three non-LPAD
        do_reset();
        drv(2'b01, OP_JALR, 64'h300, OP_ADD, 64'h0);
        drv(2'b01, OP_ADD, 64'h304, OP_ADD, 64'h0);
        idle();
        drv(2'b10, OP_JALR, 64'h0, OP_ADD, 64'h308);
        check_eq("w3_bad_pre_noviol", {63'd0, viol_w3}, 64'd0);
        check_eq("w3_bad_pre_armed", {62'd0, st_w3}, 64'd1);
        drv(2'b01, OP_ADD, 64'h30C, OP_ADD, 64'h0);
        check_eq("w3_bad_viol", {63'd0, viol_w3}, 64'd1);
        check_eq("w3_bad_pc", pc_w3, 64'h300);
        check_eq("w3_bad_cnt", {48'd0, cnt_w3}, 64'd1);
        check_eq("w3_bad_idle", {62'd0, st_w3}, 64'd0);
        idle();
        check_eq("w3_bad_pulse_end", {63'd0, viol_w3}, 64'd0);

        // W=2: back-to-back JALRs in one cycle
        do_reset();
        drv(2'b11, OP_JALR, 64'hA0, OP_JALR, 64'hB0);
        check_eq("w2_jj_viol", {63'd0, viol_w2}, 64'd1);
        check_eq("w2_jj_pc", pc_w2, 64'hA0);
        check_eq("w2_jj_rearmed", {62'd0, st_w2}, 64'd1);
        drv(2'b01, OP_LPAD, 64'hB4, OP_ADD, 64'h0);
        check_eq("w2_jj_noviol", {63'd0, viol_w2}, 64'd0);
        check_eq("w2_jj_cnt", {48'd0, cnt_w2}, 64'd1);
        check_eq("w2_jj_idle", {62'd0, st_w2}, 64'd0);

        // lock mode: port1 JALR after the locking violation is ignored
        do_reset();
        drv(2'b01, OP_JALR, 64'h100, OP_ADD, 64'h0);
        drv(2'b11, OP_ADD, 64'h104, OP_JALR, 64'h200);
        check_eq("lk_state", {62'd0, st_lk}, 64'd2);
        check_eq("lk_viol", {63'd0, viol_lk}, 64'd1);
        check_eq("lk_pc", pc_lk, 64'h100);
        check_eq("lk_cnt", {62'd0, cnt_lk}, 64'd1);
        check_eq("nolk_rearmed", {62'd0, st_w1}, 64'd1);
        drv(2'b11, OP_JALR, 64'h500, OP_ADD, 64'h504);
        check_eq("lk_hold_state", {62'd0, st_lk}, 64'd2);
        check_eq("lk_hold_noviol", {63'd0, viol_lk}, 64'd0);
        check_eq("lk_hold_cnt", {62'd0, cnt_lk}, 64'd1);
        check_eq("lk_hold_pc", pc_lk, 64'h100);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        check_eq("lk_clr_state", {62'd0, st_lk}, 64'd0);
        check_eq("lk_clr_alert", {63'd0, alert_lk}, 64'd0);
        check_eq("lk_clr_cnt", {62'd0, cnt_lk}, 64'd0);

        // reset asserted asynchronously while ARMED (and LK locked)
        do_reset();
        drv(2'b11, OP_JALR, 64'h100, OP_ADD, 64'h104);
        drv(2'b01, OP_JALR, 64'h700, OP_ADD, 64'h0);
        check_eq("ar_pre_armed", {62'd0, st_w1}, 64'd1);
        check_eq("ar_pre_alert", {63'd0, alert_w1}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_state", {62'd0, st_w1}, 64'd0);
        check_eq("ar_alert", {63'd0, alert_w1}, 64'd0);
        check_eq("ar_cnt", {48'd0, cnt_w1}, 64'd0);
        check_eq("ar_pc", pc_w1, 64'd0);
        check_eq("ar_lk_state", {62'd0, st_lk}, 64'd0);
        cif.commit_ack = 2'b00;
        @(posedge core_clk);
        #1;
        rst_n = 1'b1;

        // saturation on a 2-bit counter: 1 + 2 + 2 violations
        drv(2'b11, OP_JALR, 64'h1000, OP_JALR, 64'h1008);
        check_eq("sat_c1_cnt", {62'd0, cnt_sat}, 64'd1);
        check_eq("sat_c1_pc", pc_sat, 64'h1000);
        drv(2'b11, OP_JALR, 64'h1010, OP_JALR, 64'h1018);
        check_eq("sat_c2_cnt", {62'd0, cnt_sat}, 64'd3);
        check_eq("sat_c2_pc", pc_sat, 64'h1008);
        drv(2'b11, OP_JALR, 64'h1020, OP_JALR, 64'h1028);
        check_eq("sat_c3_cnt", {62'd0, cnt_sat}, 64'd3);
        check_eq("sat_c3_pc", pc_sat, 64'h1018);
        // clear together with two violations: violation wins
        clear = 1'b1;
        drv(2'b11, OP_JALR, 64'h1030, OP_JALR, 64'h1038);
        clear = 1'b0;
        check_eq("clrv_cnt", {62'd0, cnt_sat}, 64'd2);
        check_eq("clrv_alert", {63'd0, alert_sat}, 64'd1);
        check_eq("clrv_pc", pc_sat, 64'h1028);
        // disabled while ARMED: forced IDLE, nothing raised, count held
        en = 1'b0;
        drv(2'b11, OP_JALR, 64'h1040, OP_ADD, 64'h1044);
        en = 1'b1;
        check_eq("dis_state", {62'd0, st_sat}, 64'd0);
        check_eq("dis_noviol", {63'd0, viol_sat}, 64'd0);
        check_eq("dis_cnt", {62'd0, cnt_sat}, 64'd2);
        check_eq("dis_alert", {63'd0, alert_sat}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
